// File: rtl/atm_pkg.sv
// atm_pkg: encodings shared by the ATM session, input and transaction blocks.
// One-hot session states, input styles, status, menu and currency codes.
package atm_pkg;

  typedef enum logic [15:0] {
    ST_IDLE             = 16'h0001,
    ST_ACC_NUM          = 16'h0002,
    ST_PIN_INPUT        = 16'h0004,
    ST_MENU             = 16'h0008,
    ST_SHOW_BALANCES    = 16'h0010,
    ST_CONVERT_CURRENCY = 16'h0020,
    ST_SEL_CUR_CONV_1   = 16'h0040,
    ST_SEL_CUR_CONV_2   = 16'h0080,
    ST_WITHDRAW         = 16'h0100,
    ST_SEL_AMT_WITHDRAW = 16'h0200,
    ST_TRANSFER         = 16'h0400,
    ST_SEL_CUR_TRANSFER = 16'h0800,
    ST_SEL_AMT_TRANSFER = 16'h1000,
    ST_ERROR            = 16'h2000,
    ST_SUCCESS          = 16'h4000
  } atm_state_e;

  typedef enum logic [3:0] {
    STY_SINGLE_KEY      = 4'd1,
    STY_ACC_NUMBER      = 4'd2,
    STY_PIN_NUMBER      = 4'd3,
    STY_MENU_SELECTION  = 4'd4,
    STY_CURRENCY_TYPE   = 4'd5,
    STY_CURRENCY_AMOUNT = 4'd6
  } atm_style_e;

  typedef enum logic [3:0] {
    STAT_AMT_VALID      = 4'b0101,
    STAT_AMT_INVALID    = 4'b0110,
    STAT_EXIT           = 4'b0111,
    STAT_INPUT_COMPLETE = 4'b1000
  } atm_status_e;

  typedef enum logic [1:0] {
    MENU_BALANCE  = 2'd0,
    MENU_CONVERT  = 2'd1,
    MENU_WITHDRAW = 2'd2,
    MENU_TRANSFER = 2'd3
  } atm_menu_e;

  typedef enum logic [1:0] {
    CUR_USD = 2'd0,
    CUR_EUR = 2'd1,
    CUR_GBP = 2'd2,
    CUR_JPY = 2'd3
  } atm_currency_e;

  // Keyboard style the user-input block should use in a given state
  function automatic logic [3:0] style_of(atm_state_e s);
    logic [3:0] sty;
    sty = STY_SINGLE_KEY;
    unique case (s)
      ST_ACC_NUM,
      ST_TRANSFER:         sty = STY_ACC_NUMBER;
      ST_PIN_INPUT:        sty = STY_PIN_NUMBER;
      ST_MENU:             sty = STY_MENU_SELECTION;
      ST_SEL_CUR_CONV_1,
      ST_SEL_CUR_CONV_2,
      ST_SEL_CUR_TRANSFER: sty = STY_CURRENCY_TYPE;
      ST_SEL_AMT_WITHDRAW,
      ST_SEL_AMT_TRANSFER: sty = STY_CURRENCY_AMOUNT;
      default:             sty = STY_SINGLE_KEY;
    endcase
    return sty;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// atm_session_ctrl_if: user-input status, check and transaction handshakes.
// master = environment side, slave = session controller side.
interface atm_session_ctrl_if;
  logic        in_valid;
  logic [3:0]  status_code;
  logic [1:0]  usr_input;
  logic [15:0] current_state;
  logic [3:0]  input_style;
  logic        chk_req;
  logic        chk_pin;
  logic        chk_ack;
  logic        chk_ok;
  logic        txn_req;
  logic [1:0]  txn_op;
  logic        txn_ack;
  logic [3:0]  txn_status;
  logic        locked;
  logic [1:0]  pin_tries;

  modport master (
    output in_valid, status_code, usr_input,
    output chk_ack, chk_ok, txn_ack, txn_status,
    input  current_state, input_style,
    input  chk_req, chk_pin, txn_req, txn_op,
    input  locked, pin_tries
  );

  modport slave (
    input  in_valid, status_code, usr_input,
    input  chk_ack, chk_ok, txn_ack, txn_status,
    output current_state, input_style,
    output chk_req, chk_pin, txn_req, txn_op,
    output locked, pin_tries
  );
endinterface

// File: rtl/atm_session_ctrl_timer.sv
// session_timer: loadable saturating down-counter.
// done_o is high while one or zero cycles remain.
module session_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; counting stops at zero so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q[W-1:1] == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session sequencer with PIN lockout,
// inactivity abandon and timed SUCCESS/ERROR screens.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter logic [31:0] MSG_HOLD      = 32'd300_000_000,
  parameter logic [31:0] IDLE_TIMEOUT  = 32'd3_000_000_000,
  parameter int unsigned MAX_PIN_TRIES = 3
) (
  input  logic         clk,
  input  logic         rst,
  atm_session_ctrl_if.slave bus
);

  localparam logic [2:0] MAX_TRIES = 3'(MAX_PIN_TRIES);

  atm_state_e state_q, state_d;
  logic [3:0] style_q;
  logic       chk_req_q, chk_req_d;
  logic       chk_pin_q, chk_pin_d;
  logic       txn_req_q, txn_req_d;
  logic [1:0] txn_op_q, txn_op_d;
  logic       locked_q, locked_d;
  logic [1:0] tries_q, tries_d;
  logic       auth_q, auth_d;

  logic       pending;
  logic       in_msg;
  logic       run;
  logic       iv_live;
  logic       done_in;
  logic       exit_in;
  logic       hold_done;
  logic       idle_done;
  logic       idle_exp;
  logic [2:0] tries_inc;

  assign pending   = chk_req_q | txn_req_q;
  assign in_msg    = (state_q == ST_ERROR) | (state_q == ST_SUCCESS);
  assign run       = ~in_msg & (state_q != ST_IDLE);
  assign iv_live   = bus.in_valid & ~pending;
  assign done_in   = iv_live & (bus.status_code == STAT_INPUT_COMPLETE);
  assign exit_in   = iv_live & (bus.status_code == STAT_EXIT);
  assign idle_exp  = run & ~pending & ~bus.in_valid & idle_done;
  assign tries_inc = {1'b0, tries_q} + 3'd1;

  session_timer #(.W(32)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (~in_msg),
    .val_i  (MSG_HOLD),
    .en_i   (in_msg),
    .done_o (hold_done)
  );

  session_timer #(.W(32)) u_idle (
    .clk    (clk),
    .rst    (rst),
    .load_i (~run | iv_live),
    .val_i  (IDLE_TIMEOUT),
    .en_i   (run & ~pending),
    .done_o (idle_done)
  );

  // Next session state: acks first, then screen hold, exit, input, timeout
  always_comb begin
    state_d   = state_q;
    chk_req_d = chk_req_q;
    chk_pin_d = chk_pin_q;
    txn_req_d = txn_req_q;
    txn_op_d  = txn_op_q;
    locked_d  = locked_q;
    tries_d   = tries_q;
    auth_d    = auth_q;
    if (chk_req_q) begin
      if (bus.chk_ack) begin
        chk_req_d = 1'b0;
        if (!chk_pin_q) begin
          state_d = bus.chk_ok ? ST_PIN_INPUT : ST_ERROR;
        end else if (bus.chk_ok) begin
          tries_d = 2'd0;
          auth_d  = 1'b1;
          state_d = ST_MENU;
        end else begin
          tries_d = tries_inc[1:0];
          if (tries_inc >= MAX_TRIES) begin
            locked_d = 1'b1;
            state_d  = ST_ERROR;
          end
        end
      end
    end else if (txn_req_q) begin
      if (bus.txn_ack) begin
        txn_req_d = 1'b0;
        state_d   = (bus.txn_status == STAT_AMT_VALID) ? ST_SUCCESS : ST_ERROR;
      end
    end else if (in_msg) begin
      if (hold_done) begin
        if ((state_q == ST_SUCCESS) || (auth_q && !locked_q)) begin
          state_d = ST_MENU;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end else if (exit_in && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      auth_d  = 1'b0;
      tries_d = 2'd0;
    end else if (done_in) begin
      unique case (state_q)
        ST_IDLE:             if (!locked_q) state_d = ST_ACC_NUM;
        ST_ACC_NUM: begin
          chk_req_d = 1'b1;
          chk_pin_d = 1'b0;
        end
        ST_PIN_INPUT: begin
          chk_req_d = 1'b1;
          chk_pin_d = 1'b1;
        end
        ST_MENU: begin
          txn_op_d = bus.usr_input;
          unique case (bus.usr_input)
            MENU_BALANCE:  state_d = ST_SHOW_BALANCES;
            MENU_CONVERT:  state_d = ST_CONVERT_CURRENCY;
            MENU_WITHDRAW: state_d = ST_WITHDRAW;
            MENU_TRANSFER: state_d = ST_TRANSFER;
          endcase
        end
        ST_SHOW_BALANCES:    state_d = ST_MENU;
        ST_CONVERT_CURRENCY: state_d = ST_SEL_CUR_CONV_1;
        ST_SEL_CUR_CONV_1:   state_d = ST_SEL_CUR_CONV_2;
        ST_WITHDRAW:         state_d = ST_SEL_AMT_WITHDRAW;
        ST_TRANSFER:         state_d = ST_SEL_CUR_TRANSFER;
        ST_SEL_CUR_TRANSFER: state_d = ST_SEL_AMT_TRANSFER;
        ST_SEL_CUR_CONV_2,
        ST_SEL_AMT_WITHDRAW,
        ST_SEL_AMT_TRANSFER: txn_req_d = 1'b1;
        default: ;
      endcase
    end else if (idle_exp) begin
      state_d = ST_IDLE;
      auth_d  = 1'b0;
      tries_d = 2'd0;
    end
  end

  // Session registers; input style is registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      style_q   <= STY_SINGLE_KEY;
      chk_req_q <= 1'b0;
      chk_pin_q <= 1'b0;
      txn_req_q <= 1'b0;
      txn_op_q  <= 2'd0;
      locked_q  <= 1'b0;
      tries_q   <= 2'd0;
      auth_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      style_q   <= style_of(state_d);
      chk_req_q <= chk_req_d;
      chk_pin_q <= chk_pin_d;
      txn_req_q <= txn_req_d;
      txn_op_q  <= txn_op_d;
      locked_q  <= locked_d;
      tries_q   <= tries_d;
      auth_q    <= auth_d;
    end
  end

  assign bus.current_state = state_q;
  assign bus.input_style   = style_q;
  assign bus.chk_req       = chk_req_q;
  assign bus.chk_pin       = chk_pin_q;
  assign bus.txn_req       = txn_req_q;
  assign bus.txn_op        = txn_op_q;
  assign bus.locked        = locked_q;
  assign bus.pin_tries     = tries_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: table vectors, directed corner sequences and
// random traffic checked against a cycle-level session model.
module tb_atm_session_ctrl;

  localparam int HOLD = 4;
  localparam int TO   = 20;
  localparam int MAXT = 3;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc_n    = 0;

  atm_session_ctrl_if bus();

  atm_session_ctrl #(
    .MSG_HOLD      (32'(HOLD)),
    .IDLE_TIMEOUT  (32'(TO)),
    .MAX_PIN_TRIES (MAXT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State indices: 0 IDLE 1 ACC 2 PIN 3 MENU 4 BAL 5 CONV 6 SC1 7 SC2
  // 8 WD 9 SAW 10 TR 11 SCT 12 SAT 13 ERROR 14 SUCCESS
  // done_next: -1 start txn, -2 start check, -3 menu pick, -4 none
  int dn_next   [15];
  int sty_tab   [15];
  int menu_next [4];

  int m_st, m_op, m_tries, m_hold, m_inact;
  bit m_chk, m_pin, m_txn, m_lock, m_auth;

  typedef struct {
    logic        iv;
    logic [3:0]  code;
    logic [1:0]  usr;
    logic        ca;
    logic        co;
    logic        ta;
    logic [3:0]  ts;
    logic [15:0] st;
    logic [3:0]  sty;
    logic        creq;
    logic        treq;
    logic [1:0]  op;
  } vec_t;

  vec_t tbl [16];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] dut_vec();
    return {bus.current_state, bus.input_style, bus.chk_req, bus.chk_pin,
            bus.txn_req, bus.txn_op, bus.locked, bus.pin_tries};
  endfunction

  function automatic logic [27:0] model_vec();
    logic [15:0] oh;
    oh = 16'h0001 << m_st;
    return {oh, 4'(sty_tab[m_st]), m_chk, m_pin, m_txn, 2'(m_op),
            m_lock, 2'(m_tries)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_op = 0; m_tries = 0; m_hold = 0; m_inact = 0;
    m_chk = 0; m_pin = 0; m_txn = 0; m_lock = 0; m_auth = 0;
  endtask

  task automatic go_idle();
    m_st = 0;
    m_auth = 0;
    m_tries = 0;
  endtask

  // Advance the model by one clock using the inputs now on the bus
  task automatic model_step();
    bit pend, msg, dn, ex;
    int n;
    pend = m_chk || m_txn;
    msg  = (m_st == 13) || (m_st == 14);
    dn   = bus.in_valid && (bus.status_code == 4'b1000);
    ex   = bus.in_valid && (bus.status_code == 4'b0111);
    if (!msg) m_hold = 0;
    if (m_st == 0 || msg) m_inact = 0;
    else if (!pend && bus.in_valid) m_inact = 0;
    if (m_chk) begin
      if (bus.chk_ack) begin
        m_chk = 0;
        if (!m_pin) m_st = bus.chk_ok ? 2 : 13;
        else if (bus.chk_ok) begin
          m_tries = 0; m_auth = 1; m_st = 3;
        end else begin
          m_tries++;
          if (m_tries >= MAXT) begin m_lock = 1; m_st = 13; end
        end
      end
    end else if (m_txn) begin
      if (bus.txn_ack) begin
        m_txn = 0;
        m_st = (bus.txn_status == 4'b0101) ? 14 : 13;
      end
    end else if (msg) begin
      m_hold++;
      if (m_hold == HOLD) m_st = (m_st == 14 || (m_auth && !m_lock)) ? 3 : 0;
    end else if (ex && m_st != 0) begin
      go_idle();
    end else if (dn) begin
      n = dn_next[m_st];
      if (n == -3) begin
        m_op = int'(bus.usr_input);
        m_st = menu_next[bus.usr_input];
      end else if (n == -2) begin
        m_chk = 1; m_pin = (m_st == 2);
      end else if (n == -1) begin
        m_txn = 1;
      end else if (n >= 0 && !(m_st == 0 && m_lock)) begin
        m_st = n;
      end
    end else if (m_st != 0 && !bus.in_valid) begin
      m_inact++;
      if (m_inact >= TO) go_idle();
    end
  endtask

  task automatic drive(logic iv, logic [3:0] code, logic [1:0] usr,
                       logic ca, logic co, logic ta, logic [3:0] ts);
    bus.in_valid = iv; bus.status_code = code; bus.usr_input = usr;
    bus.chk_ack = ca; bus.chk_ok = co;
    bus.txn_ack = ta; bus.txn_status = ts;
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    check($sformatf("model_c%0d", cyc_n), {4'h0, dut_vec()}, {4'h0, model_vec()});
  endtask

  task automatic nop();            drive(0, 4'h0, 2'd0, 0, 0, 0, 4'h0); endtask
  task automatic done(logic [1:0] u); drive(1, 4'h8, u, 0, 0, 0, 4'h0); endtask
  task automatic exitk();          drive(1, 4'h7, 2'd0, 0, 0, 0, 4'h0); endtask
  task automatic cack(logic ok);   drive(0, 4'h0, 2'd0, 1, ok, 0, 4'h0); endtask
  task automatic tack(logic [3:0] s); drive(0, 4'h0, 2'd0, 0, 0, 1, s); endtask

  task automatic login();
    done(0); done(0); cack(1); done(0); cack(1);
  endtask

  task automatic clr_inputs();
    bus.in_valid = 0; bus.status_code = 0; bus.usr_input = 0;
    bus.chk_ack = 0; bus.chk_ok = 0; bus.txn_ack = 0; bus.txn_status = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int quiet;
    int r;
    logic iv, ca, co, ta;
    logic [3:0] code, ts;
    logic [1:0] usr;

    dn_next   = '{1, -2, -2, -3, 3, 6, 7, -1, 9, -1, 11, 12, -1, -4, -4};
    sty_tab   = '{1, 2, 3, 4, 1, 1, 5, 5, 1, 6, 2, 5, 6, 1, 1};
    menu_next = '{4, 5, 8, 10};

    // iv code usr ca co ta ts | state style creq treq op
    tbl[0]  = '{1, 4'h8, 2'd0, 0, 0, 0, 4'h0, 16'h0002, 4'd2, 0, 0, 2'd0};
    tbl[1]  = '{1, 4'h8, 2'd0, 0, 0, 0, 4'h0, 16'h0002, 4'd2, 1, 0, 2'd0};
    tbl[2]  = '{0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 16'h0002, 4'd2, 1, 0, 2'd0};
    tbl[3]  = '{1, 4'h7, 2'd0, 0, 0, 0, 4'h0, 16'h0002, 4'd2, 1, 0, 2'd0};
    tbl[4]  = '{0, 4'h0, 2'd0, 1, 1, 0, 4'h0, 16'h0004, 4'd3, 0, 0, 2'd0};
    tbl[5]  = '{1, 4'h8, 2'd0, 0, 0, 0, 4'h0, 16'h0004, 4'd3, 1, 0, 2'd0};
    tbl[6]  = '{0, 4'h0, 2'd0, 1, 1, 0, 4'h0, 16'h0008, 4'd4, 0, 0, 2'd0};
    tbl[7]  = '{0, 4'h0, 2'd0, 0, 0, 1, 4'h5, 16'h0008, 4'd4, 0, 0, 2'd0};
    tbl[8]  = '{1, 4'h8, 2'd2, 0, 0, 0, 4'h0, 16'h0100, 4'd1, 0, 0, 2'd2};
    tbl[9]  = '{1, 4'h8, 2'd0, 0, 0, 0, 4'h0, 16'h0200, 4'd6, 0, 0, 2'd2};
    tbl[10] = '{1, 4'h8, 2'd0, 0, 0, 0, 4'h0, 16'h0200, 4'd6, 0, 1, 2'd2};
    tbl[11] = '{0, 4'h0, 2'd0, 0, 0, 1, 4'h5, 16'h4000, 4'd1, 0, 0, 2'd2};
    tbl[12] = '{0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 16'h4000, 4'd1, 0, 0, 2'd2};
    tbl[13] = '{0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 16'h4000, 4'd1, 0, 0, 2'd2};
    tbl[14] = '{0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 16'h4000, 4'd1, 0, 0, 2'd2};
    tbl[15] = '{0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 16'h0008, 4'd4, 0, 0, 2'd2};

    rst = 1'b0;
    clr_inputs();
    model_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_state", 32'(bus.current_state), 32'h0001);
    check("rst_style", 32'(bus.input_style), 32'd1);
    check("rst_reqs", {29'd0, bus.chk_req, bus.chk_pin, bus.txn_req}, 32'd0);
    check("rst_lock_tries", {29'd0, bus.locked, bus.pin_tries}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Login, ignored inputs while pending, withdraw with success hold
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].code, tbl[i].usr, tbl[i].ca, tbl[i].co,
            tbl[i].ta, tbl[i].ts);
      check($sformatf("tbl%0d_state", i), 32'(bus.current_state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_style", i), 32'(bus.input_style), 32'(tbl[i].sty));
      check($sformatf("tbl%0d_chk_req", i), 32'(bus.chk_req), 32'(tbl[i].creq));
      check($sformatf("tbl%0d_txn_req", i), 32'(bus.txn_req), 32'(tbl[i].treq));
      check($sformatf("tbl%0d_txn_op", i), 32'(bus.txn_op), 32'(tbl[i].op));
    end

    // Convert path ending in an invalid amount: ERROR then back to MENU
    done(1);
    check("conv_state", 32'(bus.current_state), 32'h0020);
    done(0); done(0);
    check("conv2_state", 32'(bus.current_state), 32'h0080);
    done(0);
    check("conv_txn_req", 32'(bus.txn_req), 32'd1);
    check("conv_txn_op", 32'(bus.txn_op), 32'd1);
    tack(4'b0110);
    check("conv_error", 32'(bus.current_state), 32'h2000);
    repeat (3) nop();
    check("conv_error_held", 32'(bus.current_state), 32'h2000);
    nop();
    check("conv_error_menu", 32'(bus.current_state), 32'h0008);

    // EXIT from SELECT_CURRENCY_CONVERT_2
    done(1); done(0); done(0);
    exitk();
    check("exit_idle", 32'(bus.current_state), 32'h0001);
    check("exit_tries", 32'(bus.pin_tries), 32'd0);

    // Login then inactivity; a late in_valid restarts the window
    login();
    check("login_state", 32'(bus.current_state), 32'h0008);
    check("login_style", 32'(bus.input_style), 32'd4);
    check("login_tries", 32'(bus.pin_tries), 32'd0);
    repeat (19) nop();
    check("to_19", 32'(bus.current_state), 32'h0008);
    drive(1, 4'h0, 2'd0, 0, 0, 0, 4'h0);
    check("to_iv_wins", 32'(bus.current_state), 32'h0008);
    repeat (19) nop();
    check("to_19b", 32'(bus.current_state), 32'h0008);
    nop();
    check("to_idle", 32'(bus.current_state), 32'h0001);

    // Long stall with a check pending freezes everything
    done(0); done(0);
    repeat (50) nop();
    check("stall_state", 32'(bus.current_state), 32'h0002);
    check("stall_chk_req", 32'(bus.chk_req), 32'd1);
    cack(0);
    check("acc_bad", 32'(bus.current_state), 32'h2000);
    repeat (4) nop();
    check("acc_bad_idle", 32'(bus.current_state), 32'h0001);

    // PIN lockout
    done(0); done(0); cack(1);
    done(0); cack(0);
    check("pin1_tries", 32'(bus.pin_tries), 32'd1);
    check("pin1_state", 32'(bus.current_state), 32'h0004);
    done(0); cack(0);
    done(0); cack(0);
    check("lock_tries", 32'(bus.pin_tries), 32'd3);
    check("lock_flag", 32'(bus.locked), 32'd1);
    check("lock_error", 32'(bus.current_state), 32'h2000);
    repeat (3) nop();
    check("lock_error_held", 32'(bus.current_state), 32'h2000);
    nop();
    check("lock_idle", 32'(bus.current_state), 32'h0001);
    done(0);
    check("lock_ignore", 32'(bus.current_state), 32'h0001);
    check("lock_stays", 32'(bus.locked), 32'd1);

    // Asynchronous reset while a transaction is pending
    do_reset();
    login();
    done(2); done(0); done(0);
    check("mid_txn_req", 32'(bus.txn_req), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.current_state), 32'h0001);
    check("arst_style", 32'(bus.input_style), 32'd1);
    check("arst_reqs", {29'd0, bus.chk_req, bus.chk_pin, bus.txn_req}, 32'd0);
    check("arst_op", 32'(bus.txn_op), 32'd0);
    check("arst_lock_tries", {29'd0, bus.locked, bus.pin_tries}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_inputs();
    model_reset();

    // Random traffic against the model
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 99) < 3) quiet = 25;
      iv = (quiet == 0) && ($urandom_range(0, 99) < 35);
      r = $urandom_range(0, 99);
      if (r < 75) code = 4'h8;
      else if (r < 80) code = 4'h7;
      else code = 4'($urandom_range(0, 15));
      usr = 2'($urandom_range(0, 3));
      ca = ($urandom_range(0, 99) < 25);
      co = ($urandom_range(0, 99) < 85);
      ta = ($urandom_range(0, 99) < 25);
      ts = ($urandom_range(0, 99) < 70) ? 4'h5 : 4'($urandom_range(0, 15));
      drive(iv, code, usr, ca, co, ta, ts);
      if (m_lock && m_st == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Top-level ATM session sequencer.
- Owns the one-hot session state and selects the keyboard input style used by the user-input block.
- Consumes that block's completion/exit status codes and issues request/acknowledge transactions to the account-check and transaction engines.
- Counts PIN attempts, ends idle sessions on inactivity, and holds SUCCESS/ERROR screens for a fixed display time.

Parameters:
- MSG_HOLD, 300000000, cycles SUCCESS/ERROR are held (3 s at 100 MHz).
- IDLE_TIMEOUT, 3000000000, cycles with no in_valid before an authenticated or partial session is abandoned.
- MAX_PIN_TRIES, 3, consecutive wrong PINs before lockout.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  one-cycle strobe: status_code is valid
- status_code  in  4  INPUT_COMPLETE=4'b1000, EXIT=4'b0111; other codes ignored
- usr_input  in  2  menu choice: BALANCE=0, CONVERT=1, WITHDRAW=2, TRANSFER=3
- current_state  out  16  one-hot session state (encodings in package)
- input_style  out  4  SINGLE_KEY=1, ACC_NUMBER=2, PIN_NUMBER=3, MENU_SELECTION=4, CURRENCY_TYPE=5, CURRENCY_AMOUNT=6
- chk_req  out  1  account/PIN check request, level, held until chk_ack
- chk_pin  out  1  0 = account lookup, 1 = PIN check; stable while chk_req=1
- chk_ack  in  1  check done; sampled only while chk_req=1
- chk_ok  in  1  check result, valid with chk_ack
- txn_req  out  1  transaction request, level, held until txn_ack
- txn_op  out  2  usr_input captured at MENU exit; stable while txn_req=1
- txn_ack  in  1  transaction done
- txn_status  in  4  AMT_VALID=4'b0101 or AMT_INVALID=4'b0110, valid with txn_ack
- locked  out  1  set on PIN lockout; cleared only by rst
- pin_tries  out  2  wrong-PIN count

Behaviour:
- Reset (async, immediate) outputs: current_state=IDLE, input_style=SINGLE_KEY, chk_req=0, chk_pin=0, txn_req=0, txn_op=0, locked=0, pin_tries=0. All timers clear.
- Outputs are registered. A state change is visible 1 cycle after the triggering in_valid/ack. Requests assert in the cycle after INPUT_COMPLETE.
- "Done" below means in_valid=1 with status_code=INPUT_COMPLETE.
- Input style per state:
  - SINGLE_KEY: IDLE, SHOW_BALANCES, CONVERT_CURRENCY, WITHDRAW, ERROR, SUCCESS
  - ACC_NUMBER: ACC_NUM, TRANSFER
  - PIN_NUMBER: PIN_INPUT
  - MENU_SELECTION: MENU
  - CURRENCY_TYPE: SELECT_CURRENCY_CONVERT_1/2, SELECT_CURRENCY_TRANSFER
  - CURRENCY_AMOUNT: SELECT_AMOUNT_WITHDRAW/TRANSFER
- Transitions on done:
  - IDLE -> ACC_NUM; ignored while locked=1.
  - ACC_NUM: raise chk_req with chk_pin=0. On ack: chk_ok=1 -> PIN_INPUT, else -> ERROR.
  - PIN_INPUT: raise chk_req with chk_pin=1. On ack with ok: pin_tries=0 -> MENU. On ack with fail: pin_tries+1. When it reaches MAX_PIN_TRIES: locked=1 -> ERROR; otherwise remain in PIN_INPUT.
  - MENU: latch txn_op=usr_input, then BALANCE -> SHOW_BALANCES, CONVERT -> CONVERT_CURRENCY, WITHDRAW -> WITHDRAW, TRANSFER -> TRANSFER.
  - SHOW_BALANCES -> MENU.
  - CONVERT_CURRENCY -> SELECT_CURRENCY_CONVERT_1 -> SELECT_CURRENCY_CONVERT_2 -> transaction.
  - WITHDRAW -> SELECT_AMOUNT_WITHDRAW -> transaction.
  - TRANSFER -> SELECT_CURRENCY_TRANSFER -> SELECT_AMOUNT_TRANSFER -> transaction.
- Transaction: txn_req=1, current_state unchanged. On txn_ack: AMT_VALID -> SUCCESS; any other status -> ERROR.
- SUCCESS/ERROR: hold exactly MSG_HOLD cycles, ignoring in_valid. Then SUCCESS -> MENU; ERROR -> MENU if authenticated and not locked, else IDLE.
- EXIT (in_valid with status_code=EXIT), any state except IDLE/ERROR/SUCCESS: -> IDLE next cycle. Clears the authenticated flag and pin_tries.
- Pending request (chk_req or txn_req high):
  - in_valid is ignored, including EXIT.
  - The inactivity timer is frozen.
  - The request is never withdrawn before its ack.
- Inactivity timer:
  - Runs in all states except IDLE, ERROR, SUCCESS, and while a request is pending.
  - Resets on any in_valid.
  - At IDLE_TIMEOUT -> IDLE, with the same clears as EXIT.
- Simultaneous in_valid and timer expiry in the same cycle: in_valid wins.
- Ack arriving while no request is pending is ignored.
- Timers are wide enough for 3e9 cycles (32 bits) and saturate; they never wrap.

Decomposition:
- Package atm_pkg holds:
  - 16-bit one-hot state constants
  - input style codes
  - status codes
  - menu codes
  - currency codes
- atm_pkg is shared with the user-input block and the transaction engine.
- One sub-module, session_timer: loadable down-counter with a done flag, instanced for MSG_HOLD and IDLE_TIMEOUT.

Test Plan (MSG_HOLD=4, IDLE_TIMEOUT=20, MAX_PIN_TRIES=3):
- Login: done in IDLE, done in ACC_NUM, chk_ack with ok=1, done in PIN_INPUT, chk_ack with ok=1 -> current_state=MENU (16'h0008), input_style=4, pin_tries=0.
- Lockout: three PIN checks with chk_ok=0 -> pin_tries=3, locked=1, ERROR held 4 cycles, then IDLE. A subsequent done in IDLE leaves state at IDLE.
- Withdraw: MENU done with usr_input=2 -> WITHDRAW; done -> SELECT_AMOUNT_WITHDRAW; done -> txn_req=1 with txn_op=2. txn_ack with status 4'b0101 -> SUCCESS for 4 cycles -> MENU.
- Convert path with txn_status 4'b0110 -> ERROR, then MENU. EXIT injected in SELECT_CURRENCY_CONVERT_2 on another run -> IDLE next cycle.
- Timeout: stall 20 cycles in MENU -> IDLE. Stall 50 cycles with chk_req pending -> state unchanged, chk_req still 1.
- Reset mid-transaction (txn_req=1): rst pulse -> all outputs at reset values immediately, without waiting for a clock edge.
